logo_bounce: RTL and testbench

Motion controller for the on-screen logo. Watches the pixel counters from the VGA sync generator, detects the start of vertical blanking, and once every `FRAME_DIV` frames steps `x_logo`/`y_logo` by `STEP` pixels, reversing direction at screen edges. Its outputs feed the logo graphics renderer's position inputs. Positions change only during blanking, so the renderer never sees a mid-frame position change.

---
 rtl/logo_pkg.sv | 80 ++++++++
 rtl/logo_bounce_frame_tick.sv | 43 ++++
 rtl/logo_bounce.sv | 157 +++++++++++++++
 tb/tb_logo_bounce.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/logo_pkg.sv
// -----------------------------------------------------------------------------
// logo_pkg
// Shared definitions for the bouncing-logo motion controller:
//   - colour indices used by the logo renderer
//   - default screen / logo dimensions
//   - motion FSM state encoding
//   - per-axis step helper and ink sequencing helper
// -----------------------------------------------------------------------------
package logo_pkg;

  // Colour indices (3-bit RGB index as seen by the renderer)
  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  // Default screen and logo dimensions
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_WIDTH_LOGO  = 80;
  localparam int DEF_HEIGHT_LOGO = 96;

  // Motion FSM states
  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    UPD_X = 2'd1,
    UPD_Y = 2'd2
  } state_t;

  // Result of one axis step: new position, new direction, reflection flag
  typedef struct packed {
    logic [9:0] pos;
    logic       neg;  // 0 = moving right/down, 1 = moving left/up
    logic       hit;
  } axis_t;

  // One step on one axis. Sums are 11 bits wide so pos + step cannot wrap,
  // which also makes an out-of-range start position clamp to lim.
  function automatic axis_t axis_step(input logic [9:0]  pos,
                                      input logic        neg,
                                      input logic [10:0] step,
                                      input logic [10:0] lim);
    axis_t       res;
    logic [10:0] sum;
    sum     = {1'b0, pos} + step;
    res.pos = pos;
    res.neg = neg;
    res.hit = 1'b0;
    if (!neg) begin
      if (sum >= lim) begin
        res.pos = lim[9:0];
        res.neg = 1'b1;
        res.hit = 1'b1;
      end else begin
        res.pos = sum[9:0];
      end
    end else begin
      if ({1'b0, pos} <= step) begin
        res.pos = '0;
        res.neg = 1'b0;
        res.hit = 1'b1;
      end else begin
        res.pos = pos - step[9:0];
      end
    end
    return res;
  endfunction

  // Ink sequence 010 -> 011 -> 100 -> 101 -> 110 -> 001 -> 010 ...
  // Black and white are skipped so the logo never vanishes on the background.
  function automatic logic [2:0] ink_next(input logic [2:0] ink);
    logic [2:0] nxt;
    nxt = ink + 3'd1;
    if ((nxt == COLOR_WHITE) || (nxt == COLOR_BLACK)) begin
      nxt = COLOR_BLUE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/logo_bounce_frame_tick.sv
// -----------------------------------------------------------------------------
// frame_tick
// Detects the start of vertical blanking from the VGA pixel counters.
// The compare (x_px == 0 && y_px == V_ACTIVE) is registered and the tick is
// its rising edge, so a condition lasting several cycles yields one tick.
// The tick is presented in the first cycle the condition is seen; the
// consuming FSM registers it on the following edge.
//
// Ports:
//   clk   in   pixel clock
//   clr   in   asynchronous active-low reset
//   x_px  in   current pixel X
//   y_px  in   current pixel Y
//   tick  out  one-cycle frame tick
// -----------------------------------------------------------------------------
module frame_tick #(
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  output logic       tick
);

  logic w_cond;
  logic r_cond;

  assign w_cond = (x_px == 10'd0) && (y_px == 10'(V_ACTIVE));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cond <= 1'b0;
    end else begin
      r_cond <= w_cond;
    end
  end

  assign tick = w_cond && !r_cond;

endmodule

// File: rtl/logo_bounce.sv
// -----------------------------------------------------------------------------
// logo_bounce
// Motion controller for the on-screen logo. Once every FRAME_DIV frame ticks
// (counted only while run = 1) it steps x_logo then y_logo by STEP pixels,
// reflecting at the screen edges. Updates happen right after the start of
// vertical blanking, so the renderer never sees a mid-frame change.
//
// Optional feature: define LOGO_BOUNCE_COLOR_EN to make ink advance through
// 010,011,100,101,110,001 on every bounce pulse; otherwise ink is fixed 010.
//
// Ports:
//   clk     in   pixel clock
//   clr     in   asynchronous active-low reset
//   x_px    in   current pixel X
//   y_px    in   current pixel Y
//   run     in   motion enable, sampled at frame tick
//   x_logo  out  logo top-left X (registered)
//   y_logo  out  logo top-left Y (registered)
//   bounce  out  one-cycle pulse when either axis reflects
//   ink     out  logo colour index
// -----------------------------------------------------------------------------
module logo_bounce
  import logo_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int WIDTH_LOGO  = DEF_WIDTH_LOGO,
  parameter int HEIGHT_LOGO = DEF_HEIGHT_LOGO,
  parameter int STEP        = 2,
  parameter int FRAME_DIV   = 1,
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       run,
  output logic [9:0] x_logo,
  output logic [9:0] y_logo,
  output logic       bounce,
  output logic [2:0] ink
);

  localparam logic [10:0] X_MAX     = 11'(H_ACTIVE - WIDTH_LOGO);
  localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - HEIGHT_LOGO);
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [7:0]  FCNT_LAST = 8'(FRAME_DIV - 1);
  localparam logic [9:0]  X_RST     = 10'(X_INIT);
  localparam logic [9:0]  Y_RST     = 10'(Y_INIT);

  logic       w_tick;
  logic       w_tick_ok;
  logic       w_fire;
  logic       w_bounce_set;
  axis_t      w_ax;
  axis_t      w_ay;
  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_fcnt;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_neg_x;
  logic       r_neg_y;
  logic       r_hit_x;
  logic       r_bounce;

  frame_tick #(
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_tick (
    .clk  (clk),
    .clr  (clr),
    .x_px (x_px),
    .y_px (y_px),
    .tick (w_tick)
  );

  // Ticks outside WAIT are dropped: they neither count nor start an update.
  assign w_tick_ok    = w_tick && run && (r_state == WAIT);
  assign w_fire       = w_tick_ok && (r_fcnt == FCNT_LAST);
  assign w_ax         = axis_step(r_x, r_neg_x, STEP_W, X_MAX);
  assign w_ay         = axis_step(r_y, r_neg_y, STEP_W, Y_MAX);
  // X reflection is remembered from UPD_X so a corner hit gives one pulse.
  assign w_bounce_set = (r_state == UPD_Y) && (r_hit_x || w_ay.hit);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment first keeps this block free of inferred
  // latches whatever path the case statement takes.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      WAIT:    if (w_fire) w_next_state = UPD_X;
      UPD_X:   w_next_state = UPD_Y;
      UPD_Y:   w_next_state = WAIT;
      default: w_next_state = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_fcnt <= '0;
    end else if (w_tick_ok) begin
      r_fcnt <= (r_fcnt == FCNT_LAST) ? 8'd0 : r_fcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_x      <= X_RST;
      r_y      <= Y_RST;
      r_neg_x  <= 1'b0;
      r_neg_y  <= 1'b0;
      r_hit_x  <= 1'b0;
      r_bounce <= 1'b0;
    end else begin
      r_bounce <= w_bounce_set;
      if (r_state == UPD_X) begin
        r_x     <= w_ax.pos;
        r_neg_x <= w_ax.neg;
        r_hit_x <= w_ax.hit;
      end
      if (r_state == UPD_Y) begin
        r_y     <= w_ay.pos;
        r_neg_y <= w_ay.neg;
      end
    end
  end

`ifdef LOGO_BOUNCE_COLOR_EN
  logic [2:0] r_ink;

  // Advances on the same edge that raises bounce.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_ink <= COLOR_GREEN;
    end else if (w_bounce_set) begin
      r_ink <= ink_next(r_ink);
    end
  end

  assign ink = r_ink;
`else
  assign ink = COLOR_GREEN;
`endif

  assign x_logo = r_x;
  assign y_logo = r_y;
  assign bounce = r_bounce;

endmodule

// File: tb/tb_logo_bounce.sv
// -----------------------------------------------------------------------------
// tb_logo_bounce
// Four logo_bounce instances with different start positions, steps and frame
// dividers share a synthetic pixel-counter stream. A frame-level model moves
// each logo with signed velocities and compares every output cycle by cycle
// around each frame tick, including an asynchronous reset during UPD_X.
// -----------------------------------------------------------------------------
module tb_logo_bounce;

  localparam int N     = 4;
  localparam int XMAX  = 560;
  localparam int YMAX  = 384;
  localparam int XI[N] = '{100, 559, 556, 0};
  localparam int YI[N] = '{50, 0, 380, 0};
  localparam int ST[N] = '{2, 2, 2, 37};
  localparam int FD[N] = '{1, 1, 3, 2};
  localparam int INK_SEQ[6] = '{2, 3, 4, 5, 6, 1};

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [9:0]   x_px = 10'd5;
  logic [9:0]   y_px = 10'd5;
  logic [N-1:0] run = '0;

  logic [9:0] xo [N];
  logic [9:0] yo [N];
  logic       bo [N];
  logic [2:0] ko [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    logo_bounce #(
      .H_ACTIVE    (640),
      .V_ACTIVE    (480),
      .WIDTH_LOGO  (80),
      .HEIGHT_LOGO (96),
      .STEP        (ST[g]),
      .FRAME_DIV   (FD[g]),
      .X_INIT      (XI[g]),
      .Y_INIT      (YI[g])
    ) u_dut (
      .clk    (clk),
      .clr    (clr),
      .x_px   (x_px),
      .y_px   (y_px),
      .run    (run[g]),
      .x_logo (xo[g]),
      .y_logo (yo[g]),
      .bounce (bo[g]),
      .ink    (ko[g])
    );
  end

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: position, signed velocity, frame count, bounce count
  int mx [N], my [N], vx [N], vy [N], mf [N], nb [N];
  // Values before the current frame's update, and what the update does
  int ox [N], oy [N], onb [N];
  bit upd [N], hit [N];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ink_exp(input int bounces);
`ifdef LOGO_BOUNCE_COLOR_EN
    return INK_SEQ[bounces % 6];
`else
    return 2 + 0 * bounces;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = XI[i]; my[i] = YI[i];
      vx[i] = ST[i]; vy[i] = ST[i];
      mf[i] = 0;     nb[i] = 0;
      ox[i] = mx[i]; oy[i] = my[i]; onb[i] = 0;
      upd[i] = 1'b0; hit[i] = 1'b0;
    end
  endtask

  // Move along one axis: stop at the wall and reverse when reaching or passing it.
  task automatic move(input int p, input int v, input int lim,
                      output int np, output int nv, output bit h);
    np = p + v; nv = v; h = 1'b0;
    if (v > 0 && np >= lim) begin
      np = lim; nv = -v; h = 1'b1;
    end else if (v < 0 && np <= 0) begin
      np = 0; nv = -v; h = 1'b1;
    end
  endtask

  task automatic model_frame();
    int np, nv;
    bit hx, hy;
    for (int i = 0; i < N; i++) begin
      ox[i] = mx[i]; oy[i] = my[i]; onb[i] = nb[i];
      upd[i] = 1'b0; hit[i] = 1'b0;
      if (run[i]) begin
        mf[i]++;
        if (mf[i] == FD[i]) begin
          mf[i] = 0;
          upd[i] = 1'b1;
          move(mx[i], vx[i], XMAX, np, nv, hx); mx[i] = np; vx[i] = nv;
          move(my[i], vy[i], YMAX, np, nv, hy); my[i] = np; vy[i] = nv;
          hit[i] = hx | hy;
          if (hit[i]) nb[i]++;
        end
      end
    end
  endtask

  // k = cycles after the first condition cycle; k >= 4 means settled.
  task automatic check_all(input int frame, input int k);
    for (int i = 0; i < N; i++) begin
      check($sformatf("f%0d k%0d u%0d x", frame, k, i), int'(xo[i]),
            (upd[i] && k >= 2) ? mx[i] : ox[i]);
      check($sformatf("f%0d k%0d u%0d y", frame, k, i), int'(yo[i]),
            (upd[i] && k >= 3) ? my[i] : oy[i]);
      check($sformatf("f%0d k%0d u%0d bounce", frame, k, i), int'(bo[i]),
            (upd[i] && hit[i] && k == 3) ? 1 : 0);
      check($sformatf("f%0d k%0d u%0d ink", frame, k, i), int'(ko[i]),
            ink_exp((upd[i] && k >= 3) ? nb[i] : onb[i]));
    end
  endtask

  task automatic drive_noise();
    x_px = 10'($urandom_range(0, 799));
    y_px = 10'($urandom_range(0, 524));
    if (x_px == 10'd0 && y_px == 10'd480) y_px = 10'd481;
  endtask

  task automatic run_frame(input int frame, input int ncond, input bit do_reset);
    int gap;
    gap = $urandom_range(1, 3);
    for (int j = 0; j < gap; j++) begin
      @(posedge clk); #1;
      drive_noise();
      @(negedge clk);
      check_all(frame, 9);
    end
    // Cycle t: condition first seen
    @(posedge clk); #1;
    x_px = 10'd0; y_px = 10'd480;
    model_frame();
    @(negedge clk);
    check_all(frame, 0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k < ncond) begin
        x_px = 10'd0; y_px = 10'd480;
      end else begin
        drive_noise();
      end
      if (do_reset && k == 1) begin
        clr = 1'b0;
        model_reset();
      end
      if (do_reset && k == 3) clr = 1'b1;
      @(negedge clk);
      check_all(frame, k);
    end
  endtask

  initial begin
    model_reset();
    run = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset x u%0d", i), int'(xo[i]), XI[i]);
      check($sformatf("reset y u%0d", i), int'(yo[i]), YI[i]);
      check($sformatf("reset bounce u%0d", i), int'(bo[i]), 0);
      check($sformatf("reset ink u%0d", i), int'(ko[i]), 2);
    end
    @(posedge clk); #1;
    clr = 1'b1;

    // Directed frames: all running, unit 2 holds run low for frames 3 and 4
    for (int f = 0; f < 12; f++) begin
      run = '1;
      if (f == 3 || f == 4) run[2] = 1'b0;
      run_frame(f, $urandom_range(1, 3), 1'b0);
      if (f == 0) begin
        check("plan first x", int'(xo[0]), 102);
        check("plan first y", int'(yo[0]), 52);
        check("plan x clamp 560", int'(xo[1]), 560);
      end
      if (f == 1) check("plan x back 558", int'(xo[1]), 558);
      if (f == 2) check("plan div3 first", int'(xo[2]), 558);
      if (f == 4) check("plan div3 held", int'(xo[2]), 558);
      if (f == 7) begin
        check("plan corner x", int'(xo[2]), 560);
        check("plan corner y", int'(yo[2]), 384);
      end
      if (f == 10) begin
        check("plan after corner x", int'(xo[2]), 558);
        check("plan after corner y", int'(yo[2]), 382);
      end
    end

    // Reset asserted while the FSM is in UPD_X
    run = '1;
    run_frame(12, 1, 1'b1);

    // Randomized run pattern
    for (int f = 13; f < 220; f++) begin
      for (int i = 0; i < N; i++) run[i] = ($urandom_range(0, 3) != 0);
      run_frame(f, $urandom_range(1, 3), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
